// File: rtl/paillier_pkg.sv
// Shared types and defaults for the modular-exponentiation sequencer.
package paillier_pkg;

  localparam int unsigned EXP_W_DEF = 32;
  localparam int unsigned OP_W_DEF  = 32;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CHECK,
    ST_RED_ISSUE,
    ST_RED_WAIT,
    ST_SCAN,
    ST_SQ_ISSUE,
    ST_SQ_WAIT,
    ST_MUL_ISSUE,
    ST_MUL_WAIT,
    ST_FINISH
  } mexp_state_e;

  // Index width for a vector of n bits, never zero.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lead_one_detect.sv
// Combinational leading-one finder; o_idx_c is the position of the most significant set bit.
module lead_one_detect
  import paillier_pkg::*;
#(
  parameter int unsigned W = EXP_W_DEF
) (
  input  logic [W-1:0]         i_vec,
  output logic                 o_valid_c,
  output logic [idx_w(W)-1:0]  o_idx_c
);

  localparam int unsigned IW = idx_w(W);

  // Later (higher) set bits overwrite earlier ones.
  always_comb begin
    o_valid_c = |i_vec;
    o_idx_c   = '0;
    for (int unsigned i = 0; i < W; i++) begin
      if (i_vec[i]) o_idx_c = IW'(i);
    end
  end

endmodule

// File: rtl/mod_exp_sequencer.sv
// Left-to-right square-and-multiply sequencer driving an external modular multiplier.
// Define MODEXP_LZ_SKIP_EN to skip leading zero exponent bits.
module mod_exp_sequencer
  import paillier_pkg::*;
#(
  parameter int unsigned EXP_W = EXP_W_DEF,
  parameter int unsigned OP_W  = OP_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [OP_W-1:0]   base,
  input  logic [OP_W-1:0]   modulus,
  input  logic [EXP_W-1:0]  exponent,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [OP_W-1:0]   result,
  output logic              mm_start,
  output logic [OP_W-1:0]   mm_a,
  output logic [OP_W-1:0]   mm_b,
  output logic [OP_W-1:0]   mm_m,
  input  logic              mm_done,
  input  logic [2*OP_W-1:0] mm_result
);

  localparam int unsigned IW = idx_w(EXP_W);
  localparam int unsigned LW = $clog2(EXP_W + 1);

  mexp_state_e      r_state, w_state_nxt;
  logic [OP_W-1:0]  r_base, w_base_nxt;
  logic [EXP_W-1:0] r_exp, w_exp_nxt;
  logic [OP_W-1:0]  r_mod, w_mod_nxt;
  logic [OP_W-1:0]  r_acc, w_acc_nxt;
  logic [OP_W-1:0]  r_br, w_br_nxt;
  logic [IW-1:0]    r_idx, w_idx_nxt;
  logic [LW-1:0]    r_left, w_left_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic             r_err, w_err_nxt;
  logic [OP_W-1:0]  r_result, w_result_nxt;
  logic             r_mm_start, w_mm_start_nxt;
  logic [OP_W-1:0]  r_mm_a, w_mm_a_nxt;
  logic [OP_W-1:0]  r_mm_b, w_mm_b_nxt;
  logic [OP_W-1:0]  r_mm_m, w_mm_m_nxt;

  logic [OP_W-1:0]  w_mm_low;
  logic             w_unused_hi;

  // The multiplier's upper product half carries no information for us.
  assign w_mm_low    = mm_result[OP_W-1:0];
  assign w_unused_hi = ^mm_result[2*OP_W-1:OP_W];

`ifdef MODEXP_LZ_SKIP_EN
  logic          w_lead_valid;
  logic [IW-1:0] w_lead_idx;

  lead_one_detect #(.W(EXP_W)) u_lead_one (
    .i_vec     (r_exp),
    .o_valid_c (w_lead_valid),
    .o_idx_c   (w_lead_idx)
  );
`endif

  always_comb begin
    w_state_nxt    = r_state;
    w_base_nxt     = r_base;
    w_exp_nxt      = r_exp;
    w_mod_nxt      = r_mod;
    w_acc_nxt      = r_acc;
    w_br_nxt       = r_br;
    w_idx_nxt      = r_idx;
    w_left_nxt     = r_left;
    w_busy_nxt     = r_busy;
    w_done_nxt     = 1'b0;
    w_err_nxt      = r_err;
    w_result_nxt   = r_result;
    w_mm_start_nxt = 1'b0;
    w_mm_a_nxt     = r_mm_a;
    w_mm_b_nxt     = r_mm_b;
    w_mm_m_nxt     = r_mm_m;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_base_nxt  = base;
          w_exp_nxt   = exponent;
          w_mod_nxt   = modulus;
          w_mm_m_nxt  = modulus;
          w_busy_nxt  = 1'b1;
          w_state_nxt = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (r_mod == '0) begin
          w_result_nxt = '0;
          w_err_nxt    = 1'b1;
          w_done_nxt   = 1'b1;
          w_busy_nxt   = 1'b0;
          w_state_nxt  = ST_FINISH;
        end else begin
          // acc starts as 1 mod m, which is 0 for m == 1.
          w_acc_nxt      = (r_mod == OP_W'(1)) ? '0 : OP_W'(1);
          w_mm_a_nxt     = r_base;
          w_mm_b_nxt     = OP_W'(1);
          w_mm_start_nxt = 1'b1;
          w_state_nxt    = ST_RED_ISSUE;
        end
      end
      ST_RED_ISSUE: w_state_nxt = ST_RED_WAIT;
      ST_RED_WAIT: begin
        if (mm_done) begin
          w_br_nxt    = w_mm_low;
`ifdef MODEXP_LZ_SKIP_EN
          // The leading one needs no square/multiply: acc becomes b_r directly.
          w_left_nxt  = w_lead_valid ? LW'(w_lead_idx) : '0;
          w_idx_nxt   = w_lead_idx - IW'(1);
          if (w_lead_valid) w_acc_nxt = w_mm_low;
`else
          w_left_nxt  = (r_exp == '0) ? '0 : LW'(EXP_W);
          w_idx_nxt   = IW'(EXP_W - 1);
`endif
          w_state_nxt = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (r_left == '0) begin
          w_result_nxt = r_acc;
          w_err_nxt    = 1'b0;
          w_done_nxt   = 1'b1;
          w_busy_nxt   = 1'b0;
          w_state_nxt  = ST_FINISH;
        end else begin
          w_mm_a_nxt     = r_acc;
          w_mm_b_nxt     = r_acc;
          w_mm_start_nxt = 1'b1;
          w_state_nxt    = ST_SQ_ISSUE;
        end
      end
      ST_SQ_ISSUE: w_state_nxt = ST_SQ_WAIT;
      ST_SQ_WAIT: begin
        if (mm_done) begin
          w_acc_nxt = w_mm_low;
          if (r_exp[r_idx]) begin
            w_mm_a_nxt     = w_mm_low;
            w_mm_b_nxt     = r_br;
            w_mm_start_nxt = 1'b1;
            w_state_nxt    = ST_MUL_ISSUE;
          end else begin
            w_left_nxt  = r_left - LW'(1);
            w_idx_nxt   = r_idx - IW'(1);
            w_state_nxt = ST_SCAN;
          end
        end
      end
      ST_MUL_ISSUE: w_state_nxt = ST_MUL_WAIT;
      ST_MUL_WAIT: begin
        if (mm_done) begin
          w_acc_nxt   = w_mm_low;
          w_left_nxt  = r_left - LW'(1);
          w_idx_nxt   = r_idx - IW'(1);
          w_state_nxt = ST_SCAN;
        end
      end
      ST_FINISH: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_base     <= '0;
      r_exp      <= '0;
      r_mod      <= '0;
      r_acc      <= '0;
      r_br       <= '0;
      r_idx      <= '0;
      r_left     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_result   <= '0;
      r_mm_start <= 1'b0;
      r_mm_a     <= '0;
      r_mm_b     <= '0;
      r_mm_m     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_base     <= w_base_nxt;
      r_exp      <= w_exp_nxt;
      r_mod      <= w_mod_nxt;
      r_acc      <= w_acc_nxt;
      r_br       <= w_br_nxt;
      r_idx      <= w_idx_nxt;
      r_left     <= w_left_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_err      <= w_err_nxt;
      r_result   <= w_result_nxt;
      r_mm_start <= w_mm_start_nxt;
      r_mm_a     <= w_mm_a_nxt;
      r_mm_b     <= w_mm_b_nxt;
      r_mm_m     <= w_mm_m_nxt;
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign err      = r_err;
  assign result   = r_result;
  assign mm_start = r_mm_start;
  assign mm_a     = r_mm_a;
  assign mm_b     = r_mm_b;
  assign mm_m     = r_mm_m;

endmodule

// File: tb/tb_mod_exp_sequencer.sv
// Bench for mod_exp_sequencer: behavioural modular multiplier plus arithmetic reference model.
module tb_mod_exp_sequencer;

  localparam int unsigned EXP_W = 32;
  localparam int unsigned OP_W  = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [OP_W-1:0]   base = '0;
  logic [OP_W-1:0]   modulus = '0;
  logic [EXP_W-1:0]  exponent = '0;
  logic              busy, done, err;
  logic [OP_W-1:0]   result;
  logic              mm_start;
  logic [OP_W-1:0]   mm_a, mm_b, mm_m;
  logic              mm_done = 1'b0;
  logic [2*OP_W-1:0] mm_result = '0;

  always #5 clk = ~clk;

  mod_exp_sequencer #(.EXP_W(EXP_W), .OP_W(OP_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base      (base),
    .modulus   (modulus),
    .exponent  (exponent),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .result    (result),
    .mm_start  (mm_start),
    .mm_a      (mm_a),
    .mm_b      (mm_b),
    .mm_m      (mm_m),
    .mm_done   (mm_done),
    .mm_result (mm_result)
  );

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, expv);
    end
  endtask

  // Multiplier model state; it shares rst with the sequencer.
  int          mm_cnt    = 0;
  int          proto_err = 0;
  bit          mm_pend   = 1'b0;
  int          mm_lat    = 0;
  bit          slow_mm   = 1'b0;
  logic [31:0] cap_a = '0, cap_b = '0, cap_m = '0;
  logic [31:0] job_mod = '0;

  initial begin
    forever begin
      @(negedge clk);
      mm_done = 1'b0;
      if (rst) begin
        mm_pend = 1'b0;
        continue;
      end
      if (mm_pend) begin
        if (mm_lat == 0) begin
          if (mm_a !== cap_a || mm_b !== cap_b || mm_m !== cap_m) proto_err++;
          mm_result[63:32] = $urandom;
          mm_result[31:0]  = (cap_m == 0) ? 32'd0
                           : 32'((64'(cap_a) * 64'(cap_b)) % 64'(cap_m));
          mm_done = 1'b1;
          mm_pend = 1'b0;
        end else begin
          mm_lat--;
        end
      end
      if (mm_start) begin
        mm_cnt++;
        if (mm_pend || mm_done) proto_err++;
        if (mm_m !== job_mod) proto_err++;
        cap_a   = mm_a;
        cap_b   = mm_b;
        cap_m   = mm_m;
        mm_pend = 1'b1;
        mm_lat  = slow_mm ? 6 : int'($urandom_range(0, 3));
      end
    end
  end

  // Right-to-left binary exponentiation: a different route to the same value.
  function automatic logic [31:0] ref_pow(input logic [31:0] b, input logic [31:0] e,
                                          input logic [31:0] m);
    longint unsigned r, x, mm;
    logic [31:0] ee;
    if (m == 0) return 32'd0;
    mm = 64'(m);
    r  = 64'd1 % mm;
    x  = 64'(b) % mm;
    ee = e;
    while (ee != 0) begin
      if (ee[0]) r = (r * x) % mm;
      x  = (x * x) % mm;
      ee = ee >> 1;
    end
    return r[31:0];
  endfunction

  // Multiplier operations a job should cost: one reduction plus the exponent's squares/multiplies.
  function automatic int ref_ops(input logic [31:0] e, input logic [31:0] m);
    int pop, msb;
    if (m == 0) return 0;
    if (e == 0) return 1;
    pop = $countones(e);
    msb = 0;
    for (int i = 0; i < 32; i++) if (e[i]) msb = i;
`ifdef MODEXP_LZ_SKIP_EN
    return 1 + msb + (pop - 1);
`else
    return 1 + 32 + pop;
`endif
  endfunction

  task automatic run_job(input string tag, input logic [31:0] b, input logic [31:0] e,
                         input logic [31:0] m, input logic [31:0] want,
                         input int want_ops, output int cyc);
    job_mod   = m;
    mm_cnt    = 0;
    proto_err = 0;
    @(negedge clk);
    start = 1'b1; base = b; exponent = e; modulus = m;
    @(negedge clk);
    start = 1'b0; base = $urandom; exponent = $urandom; modulus = $urandom;
    cyc = 1;
    while (!done && cyc < 3000) begin
      // A second request while busy must be ignored.
      start = busy && (cyc == 3 || cyc == 4);
      if (start) begin
        base = $urandom; exponent = $urandom; modulus = $urandom;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check_eq({tag, "_done_seen"}, 64'(done), 64'd1);
    check_eq({tag, "_result"}, 64'(result), 64'(want));
    check_eq({tag, "_err"}, 64'(err), (m == 0) ? 64'd1 : 64'd0);
    check_eq({tag, "_busy_low"}, 64'(busy), 64'd0);
    check_eq({tag, "_mm_ops"}, 64'(mm_cnt), 64'(want_ops));
    check_eq({tag, "_mm_proto"}, 64'(proto_err), 64'd0);
    @(negedge clk);
    check_eq({tag, "_done_pulse"}, 64'(done), 64'd0);
    repeat (3) @(negedge clk);
    check_eq({tag, "_no_stray_job"}, {62'd0, busy, done}, 64'd0);
    check_eq({tag, "_result_held"}, 64'(result), 64'(want));
  endtask

  int cyc;
  logic [31:0] rb, re, rm;

  initial begin
    int ops_4_13;
`ifdef MODEXP_LZ_SKIP_EN
    ops_4_13 = 6;
`else
    ops_4_13 = 36;
`endif
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_err", 64'(err), 64'd0);
    check_eq("rst_result", 64'(result), 64'd0);
    check_eq("rst_mm_start", 64'(mm_start), 64'd0);
    check_eq("rst_mm_abm", {mm_a, mm_b} | 64'(mm_m), 64'd0);
    rst = 1'b0;

    run_job("pow_4_13_497", 32'd4, 32'd13, 32'd497, 32'd445, ops_4_13, cyc);
    run_job("pow_20_3_7", 32'd20, 32'd3, 32'd7, 32'd6, ref_ops(32'd3, 32'd7), cyc);
    run_job("exp0", 32'd7, 32'd0, 32'd13, 32'd1, 1, cyc);
    run_job("mod1", 32'd123456, 32'd77, 32'd1, 32'd0, ref_ops(32'd77, 32'd1), cyc);
    run_job("mod1_exp0", 32'd5, 32'd0, 32'd1, 32'd0, 1, cyc);
    run_job("mod0", 32'd9, 32'd5, 32'd0, 32'd0, 0, cyc);
    check_eq("mod0_latency_le3", 64'(cyc <= 3), 64'd1);

    // Reset while a square is outstanding at the multiplier.
    job_mod   = 32'd497;
    mm_cnt    = 0;
    slow_mm   = 1'b1;
    @(negedge clk);
    start = 1'b1; base = 32'd4; exponent = 32'd13; modulus = 32'd497;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (mm_cnt < 5 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("midjob_reached_sq", 64'(mm_cnt >= 5), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    slow_mm = 1'b0;
    check_eq("midrst_busy", 64'(busy), 64'd0);
    check_eq("midrst_mm_start", 64'(mm_start), 64'd0);
    check_eq("midrst_result", 64'(result), 64'd0);
    repeat (10) @(negedge clk);
    check_eq("midrst_idle", {62'd0, busy, done}, 64'd0);
    run_job("post_rst_4_13_497", 32'd4, 32'd13, 32'd497, 32'd445, ops_4_13, cyc);

    for (int i = 0; i < 16; i++) begin
      rb = $urandom;
      re = (i % 3 == 0) ? 32'($urandom_range(0, 255)) : $urandom;
      rm = (i % 4 == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      run_job($sformatf("rand%0d", i), rb, re, rm, ref_pow(rb, re, rm), ref_ops(re, rm), cyc);
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
